// File: rtl/ins_fetcher.sv
// Instruction-fetch front end: owns the PC and a direct-mapped one-instruction-per-line
// cache, requests misses from the memory adapter and serves the decoder via valid/ready.
module ins_fetcher #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          LINES_LOG2 = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic [31:0] flush_target_pc,
    output logic        try_start_insfetch_task,
    output logic [31:0] insfetch_addr,
    input  logic        insfetch_task_done,
    input  logic [31:0] insfetch_ins_full,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    output logic        ins_is_compressed
);

    localparam int LINES = 1 << LINES_LOG2;
    localparam int TAG_W = 31 - LINES_LOG2;

    typedef enum logic {SERVE, MISS} state_t;

    state_t                state, state_next;
    logic [31:0]           pc, pc_next;
    logic                  redirect_q, redirect_next;
    logic                  fill;
    logic [LINES-1:0]      line_valid;
    logic [TAG_W-1:0]      line_tag  [LINES];
    logic [31:0]           line_data [LINES];
    logic [LINES_LOG2-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic                  hit;

    // Half-word indexing: PCs differing only in bit 1 use separate lines.
    assign index = pc[LINES_LOG2:1];
    assign tag   = pc[31:LINES_LOG2+1];
    assign hit   = line_valid[index] && (line_tag[index] == tag);

    assign ins_pc            = pc;
    assign ins_data          = line_data[index];
    assign ins_is_compressed = (ins_data[1:0] != 2'b11);
    assign insfetch_addr     = pc;

    always_comb begin
        state_next              = state;
        pc_next                 = pc;
        redirect_next           = redirect_q;
        fill                    = 1'b0;
        ins_valid               = 1'b0;
        try_start_insfetch_task = 1'b0;

        // A flush that lands while a request is up keeps the request up if the new PC misses.
        case (state)
            SERVE: begin
                ins_valid               = hit;
                try_start_insfetch_task = redirect_q && !hit;
            end
            MISS: try_start_insfetch_task = 1'b1;
            default: ;
        endcase

        if (rdy_in) begin
            redirect_next = 1'b0;
            if (flush_pipline) begin
                pc_next       = {flush_target_pc[31:1], 1'b0};
                state_next    = SERVE;
                redirect_next = try_start_insfetch_task;
            end else begin
                case (state)
                    SERVE: begin
                        if (hit) begin
                            if (ins_ready)
                                pc_next = pc + (ins_is_compressed ? 32'd2 : 32'd4);
                        end else begin
                            state_next = MISS;
                        end
                    end
                    MISS: begin
                        if (insfetch_task_done) begin
                            fill       = 1'b1;
                            state_next = SERVE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= SERVE;
            pc         <= RESET_PC;
            redirect_q <= 1'b0;
            line_valid <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            redirect_q <= redirect_next;
            if (fill)
                line_valid[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && fill) begin
            line_tag[index]  <= tag;
            line_data[index] <= insfetch_ins_full;
        end
    end

endmodule

// File: tb/tb_ins_fetcher.sv
// Testbench for ins_fetcher: directed scenarios followed by randomized traffic against
// an address-keyed behavioural model of the fetcher and a latency-randomizing adapter.
module tb_ins_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_pipline = 1'b0;
    logic [31:0] flush_target_pc = '0;
    logic        try_start_insfetch_task;
    logic [31:0] insfetch_addr;
    logic        insfetch_task_done = 1'b0;
    logic [31:0] insfetch_ins_full = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_is_compressed;

    ins_fetcher #(.RESET_PC(32'h0), .LINES_LOG2(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .flush_pipline(flush_pipline), .flush_target_pc(flush_target_pc),
        .try_start_insfetch_task(try_start_insfetch_task), .insfetch_addr(insfetch_addr),
        .insfetch_task_done(insfetch_task_done), .insfetch_ins_full(insfetch_ins_full),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
        .ins_pc(ins_pc), .ins_is_compressed(ins_is_compressed)
    );

    always #5 clk_in = ~clk_in;

    int errCount   = 0;
    int checkCount = 0;

    // Model: the cache is remembered as "which full address sits in each line".
    logic [31:0] mPc;
    bit          mWaiting;
    bit          mRedir;
    bit          mLineValid [16];
    logic [31:0] mLineAddr  [16];
    logic [31:0] mLineData  [16];

    logic        sValid, sReq, sComp;
    logic [31:0] sPc, sData, sAddr;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic int lineOf(input logic [31:0] a);
        return int'((a / 2) % 16);
    endfunction

    function automatic bit modelCached(input logic [31:0] a);
        return mLineValid[lineOf(a)] && (mLineAddr[lineOf(a)] == a);
    endfunction

    function automatic bit modelReq();
        return mWaiting || (mRedir && !modelCached(mPc));
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        h = h ^ (h >> 15);
        if (h[7]) return {16'h0, h[15:2], 2'b01};
        return {h[31:2], 2'b11};
    endfunction

    task automatic modelReset();
        mPc = 32'h0;
        mWaiting = 1'b0;
        mRedir = 1'b0;
        for (int i = 0; i < 16; i++) mLineValid[i] = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk_in);
        rst_in = 1'b1;
        rdy_in = 1'b1;
        flush_pipline = 1'b0;
        insfetch_task_done = 1'b0;
        ins_ready = 1'b0;
        @(posedge clk_in);
        modelReset();
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic applyStimulus(input bit rdy, input bit flush, input logic [31:0] target,
                                 input bit ready, input bit done, input logic [31:0] full);
        bit          expHit, expReq, expComp;
        logic [31:0] expData;
        @(negedge clk_in);
        rst_in = 1'b0;
        rdy_in = rdy;
        flush_pipline = flush;
        flush_target_pc = target;
        ins_ready = ready;
        insfetch_task_done = done;
        insfetch_ins_full = full;
        #1;
        sValid = ins_valid; sReq = try_start_insfetch_task; sComp = ins_is_compressed;
        sPc = ins_pc; sData = ins_data; sAddr = insfetch_addr;

        expHit  = !mWaiting && modelCached(mPc);
        expReq  = modelReq();
        expData = mLineData[lineOf(mPc)];
        expComp = (expData[1:0] != 2'b11);
        checkOutput("ins_valid", {31'b0, sValid}, {31'b0, expHit});
        checkOutput("ins_pc", sPc, mPc);
        checkOutput("request", {31'b0, sReq}, {31'b0, expReq});
        if (expReq) checkOutput("insfetch_addr", sAddr, mPc);
        if (expHit) begin
            checkOutput("ins_data", sData, expData);
            checkOutput("ins_is_compressed", {31'b0, sComp}, {31'b0, expComp});
        end

        if (rdy) begin
            if (flush) begin
                mRedir = expReq;
                mPc = target & 32'hFFFF_FFFE;
                mWaiting = 1'b0;
            end else begin
                mRedir = 1'b0;
                if (mWaiting) begin
                    if (done) begin
                        mLineValid[lineOf(mPc)] = 1'b1;
                        mLineAddr[lineOf(mPc)] = mPc;
                        mLineData[lineOf(mPc)] = full;
                        mWaiting = 1'b0;
                    end
                end else if (expHit) begin
                    if (ready) mPc = mPc + (expComp ? 32'd2 : 32'd4);
                end else begin
                    mWaiting = 1'b1;
                end
            end
        end
        @(posedge clk_in);
    endtask

    task automatic step(input bit ready);
        applyStimulus(1'b1, 1'b0, 32'h0, ready, 1'b0, 32'h0);
    endtask

    task automatic flushTo(input logic [31:0] a);
        applyStimulus(1'b1, 1'b1, a, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic fillWith(input logic [31:0] d);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, d);
    endtask

    initial begin
        bit          rdy, flush, ready, done;
        logic [31:0] target, full;
        int          aCnt;

        doReset();
        step(1'b1);
        checkOutput("reset ins_valid", {31'b0, sValid}, 32'h0);
        checkOutput("reset request", {31'b0, sReq}, 32'h0);
        checkOutput("reset addr", sAddr, 32'h0);
        step(1'b1);
        checkOutput("cold request", {31'b0, sReq}, 32'h1);
        checkOutput("cold addr", sAddr, 32'h0);
        repeat (3) step(1'b1);
        fillWith(32'h00500093);
        step(1'b1);
        checkOutput("cold valid", {31'b0, sValid}, 32'h1);
        checkOutput("cold data", sData, 32'h00500093);
        flushTo(32'h10);
        checkOutput("cold advance", sPc, 32'h4);

        step(1'b1);
        fillWith(32'h00004505);
        step(1'b1);
        checkOutput("c.li compressed", {31'b0, sComp}, 32'h1);
        checkOutput("c.li pc", sPc, 32'h10);
        step(1'b1);
        checkOutput("c step pc", sPc, 32'h12);
        fillWith(32'h00a00113);
        step(1'b1);

        flushTo(32'h4);
        step(1'b0); fillWith(32'h00100113); step(1'b1);
        step(1'b0); fillWith(32'h00200193); step(1'b1);
        step(1'b0); fillWith(32'h00300213); step(1'b1);
        flushTo(32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            checkOutput("stream valid", {31'b0, sValid}, 32'h1);
            checkOutput("stream no request", {31'b0, sReq}, 32'h0);
            checkOutput("stream pc", sPc, 32'(4 * i));
        end

        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            checkOutput("backpressure pc", sPc, 32'h10);
            checkOutput("backpressure data", sData, 32'h00004505);
        end
        step(1'b1);
        step(1'b0);
        checkOutput("after backpressure pc", sPc, 32'h12);

        flushTo(32'h30);
        step(1'b0);
        step(1'b0);
        checkOutput("miss addr 0x30", sAddr, 32'h30);
        flushTo(32'h40);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        checkOutput("redirect request", {31'b0, sReq}, 32'h1);
        checkOutput("redirect addr", sAddr, 32'h40);
        fillWith(32'h00400293);
        step(1'b0);
        checkOutput("0x40 valid", {31'b0, sValid}, 32'h1);
        flushTo(32'h30);
        step(1'b0);
        checkOutput("stale not written", {31'b0, sValid}, 32'h0);

        flushTo(32'h0);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, i[0], 32'h80, 1'b1, 1'b1, 32'h12345678);
            checkOutput("stall request", {31'b0, sReq}, 32'h1);
            checkOutput("stall addr", sAddr, 32'h0);
        end
        fillWith(32'h00500093);
        step(1'b0);
        checkOutput("after stall valid", {31'b0, sValid}, 32'h1);
        flushTo(32'h20);
        step(1'b0);
        fillWith(32'h00600313);
        step(1'b0);
        checkOutput("0x20 valid", {31'b0, sValid}, 32'h1);
        flushTo(32'h0);
        step(1'b0);
        checkOutput("evicted 0x0", {31'b0, sValid}, 32'h0);
        fillWith(32'h00500093);
        step(1'b1);

        flushTo(32'hFFFF_FFFC);
        step(1'b0);
        fillWith(32'h00700393);
        step(1'b1);
        step(1'b0);
        checkOutput("wrap pc", sPc, 32'h0);

        aCnt = -1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 999) == 0) begin
                doReset();
                aCnt = -1;
            end
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else target = $urandom_range(0, 95);
            ready = ($urandom_range(0, 3) != 0);
            done  = 1'b0;
            full  = 32'h0;
            if (!modelReq()) aCnt = -1;
            else if (aCnt < 0) aCnt = int'($urandom_range(0, 4));
            if (modelReq() && aCnt == 0 && rdy) begin
                done = 1'b1;
                full = memWord(mPc);
                aCnt = -1;
            end else if (modelReq() && rdy && aCnt > 0) begin
                aCnt--;
            end
            if (!done && $urandom_range(0, 29) == 0) begin
                done = 1'b1;
                full = $urandom();
            end
            if (flush) aCnt = -1;
            applyStimulus(rdy, flush, target, ready, done, full);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ins_fetcher.md
# ins_fetcher

Instruction-fetch front end that sits directly upstream of the memory adapter's instruction-fetch port. It owns the program counter and a direct-mapped instruction cache. It issues fetch tasks to the memory adapter on a miss, and presents one instruction per cycle (RV32C-aware, 2- or 4-byte step) to the decoder through a valid/ready handshake. A pipeline flush redirects the PC and discards any in-flight miss.

## Interface
- `RESET_PC`, default 32'h0: PC value loaded on reset.
- `LINES_LOG2`, default 4: log2 of cache entries; one 32-bit instruction per entry.
- `clk_in` input 1: system clock.
- `rst_in` input 1: reset. One clock; reset is synchronous and active-high.
- `rdy_in` input 1: global ready; when low, all state holds.
- `flush_pipline` input 1: redirect request; same signal that flushes the memory adapter.
- `flush_target_pc` input 32: new PC, valid with `flush_pipline`.
- `try_start_insfetch_task` output 1: fetch request to the memory adapter; level, held until done.
- `insfetch_addr` output 32: fetch address; equals the PC while the request is asserted.
- `insfetch_task_done` input 1: one-cycle pulse; `insfetch_ins_full` is valid in that cycle.
- `insfetch_ins_full` input 32: fetched instruction; upper 16 bits are zero when compressed.
- `ins_valid` output 1: instruction available to the decoder.
- `ins_ready` input 1: decoder accepts the instruction this cycle.
- `ins_data` output 32: instruction word.
- `ins_pc` output 32: address of `ins_data`.
- `ins_is_compressed` output 1: `ins_data[1:0] != 2'b11`.

## Operation
- **Cache entry fields:** `valid`, `tag`, and a 32-bit instruction.
- **Address split:**
  - index = `pc[LINES_LOG2:1]` (half-word granularity).
  - tag = `pc[31:LINES_LOG2+1]`.
  - `pc[0]` is always 0.
- **SERVE state:**
  - hit = `valid[index] && tag match`.
  - `ins_valid` = hit. `ins_data` and `ins_pc` are driven combinationally from the array and the PC register.
  - On `ins_valid && ins_ready`: PC advances by 2 if `ins_is_compressed`, else by 4. Arithmetic is mod 2^32; wrap from 32'hFFFFFFFC to 0 is legal.
  - On a miss: next state is MISS.
- **MISS state:**
  - `try_start_insfetch_task` = 1 and `insfetch_addr` = PC.
  - `ins_valid` = 0.
  - On `insfetch_task_done`: write {valid=1, tag, `insfetch_ins_full`} at the index, then go to SERVE.
- **Flush** (highest priority after reset, with `rdy_in` high):
  - PC <= `flush_target_pc` with bit 0 cleared; state <= SERVE.
  - A `insfetch_task_done` in the same cycle is ignored; no cache write.
  - Cache contents are kept.
- **Stale done:** a `insfetch_task_done` received in SERVE is ignored.
- **`rdy_in` low:** no register changes. Outputs reflect the held state; a done pulse in that cycle is dropped.
- **Reset:**
  - all valid bits <= 0; PC <= `RESET_PC`; state <= SERVE.
  - `ins_valid` = 0 on the first post-reset cycle (miss), then `try_start_insfetch_task` = 1.
- **Indexing note:** an instruction whose PC differs only in bit 1 maps to a different entry. There is no aliasing between 2-byte offsets.

## Timing
- Hit: `ins_valid` is asserted in the same cycle the PC register holds the address (0-cycle lookup). Sustained throughput is 1 instruction per cycle.
- Miss detected in cycle N: `try_start_insfetch_task` rises at N+1 and stays high through the done cycle D. It falls at D+1; `ins_valid` = 1 at D+1.
- Request drop: the request drops only on done, flush or reset, never spontaneously.
- Flush in cycle F: the new PC is looked up at F+1. The request deasserts at F+1 if the lookup hits, and stays asserted (new address) if it misses.
- Handshake: `ins_data`/`ins_pc` are stable while `ins_valid && !ins_ready`.
- Reset values: `try_start_insfetch_task`=0, `insfetch_addr`=`RESET_PC`, `ins_valid`=0.

## Test plan
- **Reset cold start:** reset, `RESET_PC`=0; adapter model returns 32'h00500093 after 5 cycles. Required: request high at cycle 1 with address 0; `ins_valid`=1 with `ins_pc`=0 and `ins_data`=32'h00500093 one cycle after done; PC becomes 4 when accepted.
- **Compressed step:** memory at 0x10 holds 16'h4505 (c.li), at 0x12 holds a 32-bit word. Required: `ins_is_compressed`=1 at PC 0x10; next `ins_pc`=0x12.
- **Hit streaming:** loop 0x0–0xC fetched once, then PC is flushed back to 0. Required: 4 consecutive `ins_valid` cycles with `ins_ready`=1 and no request asserted.
- **Backpressure:** `ins_ready`=0 for 3 cycles on a hit. Required: `ins_pc` and `ins_data` unchanged and PC not advanced.
- **Flush during miss:** flush to 0x40 one cycle before done. Required: the stale done is not written (the entry for the old PC stays invalid), and a new request is issued with address 0x40.
- **Stall and conflict:** `rdy_in`=0 mid-miss for 4 cycles, then index conflict at 0x0 and 0x20 (LINES_LOG2=4). Required: no state change while stalled; 0x20 evicts 0x0, so refetching 0x0 misses.
